// File: rtl/fetch_sequencer_if.sv
// ---------------------------------------------------------------------------
// fetch_sequencer_if
//   Bundles the fetch-stage signals exchanged between the control/ROM side
//   (master) and the PC sequencer (slave).
//
//   master drives : start, instr, PCSrc, lut_we, lut_waddr, lut_wdata, prog_end
//   slave drives  : pc, running, done, cycle_count
// ---------------------------------------------------------------------------
interface fetch_sequencer_if #(
    parameter int PC_W   = 10,
    parameter int LUT_AW = 3,
    parameter int CNT_W  = 16
);
    logic              start;
    logic [8:0]        instr;
    logic              PCSrc;
    logic              lut_we;
    logic [LUT_AW-1:0] lut_waddr;
    logic [PC_W-1:0]   lut_wdata;
    logic [PC_W-1:0]   prog_end;
    logic [PC_W-1:0]   pc;
    logic              running;
    logic              done;
    logic [CNT_W-1:0]  cycle_count;

    modport master (
        output start, instr, PCSrc, lut_we, lut_waddr, lut_wdata, prog_end,
        input  pc, running, done, cycle_count
    );

    modport slave (
        input  start, instr, PCSrc, lut_we, lut_waddr, lut_wdata, prog_end,
        output pc, running, done, cycle_count
    );
endinterface

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//   Program counter and fetch sequencing stage ahead of the decoder/control.
//   Owns the PC, steps it once per instruction, redirects it through a small
//   writable jump-target LUT on PCSrc, and frames one program execution with
//   an IDLE -> LOAD -> RUN -> DONE sequence. Counts RUN cycles.
//
//   Ports:
//     clk    : system clock, rising-edge
//     reset  : synchronous, active-high; clears FSM, PC, counter and LUT
//     bus    : fetch_sequencer_if.slave
//                in : start, instr, PCSrc, lut_we, lut_waddr, lut_wdata,
//                     prog_end
//                out: pc, running, done, cycle_count
// ---------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int PC_W   = 10,
    parameter int LUT_AW = 3,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    fetch_sequencer_if.slave    bus
);

    localparam int LUT_N = 1 << LUT_AW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Counter stops at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end
        return v + 1'b1;
    endfunction

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              running_q, running_d;
    logic              done_q, done_d;
    logic [PC_W-1:0]   lut_q [LUT_N];
    logic [PC_W-1:0]   lut_d [LUT_N];
    logic [PC_W-1:0]   jump_target;

    // Combinational LUT read uses the pre-write contents, so a same-cycle
    // write to the branch index only becomes visible on the next branch.
    assign jump_target = lut_q[bus.instr[LUT_AW-1:0]];

    always_comb begin
        lut_d = lut_q;
        if (bus.lut_we) begin
            lut_d[bus.lut_waddr] = bus.lut_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;

        if (bus.start) begin
            // start re-initialises from any state and holds LOAD while high
            state_d = ST_LOAD;
            pc_d    = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_LOAD: state_d = ST_RUN;
                ST_RUN: begin
                    cnt_d = sat_inc(cnt_q);
                    // A taken branch wins over end-of-program detection.
                    if (bus.PCSrc) begin
                        pc_d = jump_target;
                    end else if (pc_q == bus.prog_end) begin
                        state_d = ST_DONE;
                    end else begin
                        pc_d = pc_q + 1'b1;  // natural wrap at 2**PC_W
                    end
                end
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end

        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < LUT_N; i++) begin
                lut_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            running_q <= running_d;
            done_q    <= done_d;
            for (int i = 0; i < LUT_N; i++) begin
                lut_q[i] <= lut_d[i];
            end
        end
    end

    assign bus.pc          = pc_q;
    assign bus.running     = running_q;
    assign bus.done        = done_q;
    assign bus.cycle_count = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//   Scoreboard bench: a driver applies inputs on the falling edge, advances a
//   behavioural model of the program sequence and queues the expected
//   outputs; a monitor pops and compares after every rising edge.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;
    localparam int PC_W   = 10;
    localparam int LUT_AW = 3;
    localparam int CNT_W  = 16;
    localparam int PC_MOD  = 1 << PC_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // model modes
    localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_DONE = 3;

    logic clk = 1'b0;
    logic reset;

    fetch_sequencer_if #(.PC_W(PC_W), .LUT_AW(LUT_AW), .CNT_W(CNT_W)) bus ();

    fetch_sequencer #(.PC_W(PC_W), .LUT_AW(LUT_AW), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mode;
        int pc;
        int cnt;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // reference model state
    int m_mode = M_IDLE;
    int m_pc   = 0;
    int m_cnt  = 0;
    int m_lut [8];
    int m_pend = 0;

    task automatic step(input bit rst, input bit st, input int ins,
                        input bit src, input bit we, input int wa, input int wd);
        int   tgt;
        exp_t e;
        @(negedge clk);
        reset         = rst;
        bus.start     = st;
        bus.instr     = 9'(ins);
        bus.PCSrc     = src;
        bus.lut_we    = we;
        bus.lut_waddr = 3'(wa);
        bus.lut_wdata = 10'(wd);
        bus.prog_end  = 10'(m_pend);
        if (rst) begin
            m_mode = M_IDLE; m_pc = 0; m_cnt = 0;
            foreach (m_lut[i]) m_lut[i] = 0;
        end else begin
            tgt = m_lut[ins % 8];           // old entry before any write
            if (we) m_lut[wa % 8] = wd % PC_MOD;
            if (st) begin
                m_mode = M_LOAD; m_pc = 0; m_cnt = 0;
            end else if (m_mode == M_LOAD) begin
                m_mode = M_RUN;
            end else if (m_mode == M_RUN) begin
                m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
                if (src)                  m_pc = tgt;
                else if (m_pc == m_pend)  m_mode = M_DONE;
                else                      m_pc = (m_pc + 1) % PC_MOD;
            end
        end
        e.mode = m_mode; e.pc = m_pc; e.cnt = m_cnt;
        q.push_back(e);
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic lut_write(input int wa, input int wd);
        step(1'b0, 1'b0, 0, 1'b0, 1'b1, wa, wd);
    endtask

    task automatic start_prog();
        step(1'b0, 1'b1, 0, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b1, 0, 1'b0, 1'b0, 0, 0);
        idle_step();                        // LOAD -> RUN
    endtask

    // run plain increments until model pc equals target in RUN (bounded)
    task automatic run_to_pc(input int target);
        int n = 0;
        while (!(m_mode == M_RUN && m_pc == target) && n < 2000) begin
            idle_step();
            n++;
        end
        if (n >= 2000) begin
            tests++; fails++;
            $display("FAIL run_to_pc timeout: model pc %0d, wanted %0d", m_pc, target);
        end
    endtask

    task automatic run_to_done();
        int n = 0;
        while (m_mode == M_RUN && n < 2000) begin
            idle_step();
            n++;
        end
    endtask

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                tests++;
                if (bus.pc !== 10'(e.pc) || bus.cycle_count !== 16'(e.cnt) ||
                    bus.running !== (e.mode == M_RUN) || bus.done !== (e.mode == M_DONE)) begin
                    fails++;
                    $display("FAIL cycle t=%0t: pc=%h run=%b done=%b cnt=%0d, required pc=%h run=%b done=%b cnt=%0d",
                             $time, bus.pc, bus.running, bus.done, bus.cycle_count,
                             10'(e.pc), (e.mode == M_RUN), (e.mode == M_DONE), e.cnt);
                end
            end
        end
    end

    initial begin
        foreach (m_lut[i]) m_lut[i] = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.instr = '0; bus.PCSrc = 1'b0;
        bus.lut_we = 1'b0; bus.lut_waddr = '0; bus.lut_wdata = '0; bus.prog_end = '0;

        // reset state
        step(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 0);
        idle_step();

        // short linear program 0..3 then DONE with count 4
        m_pend = 3;
        start_prog();
        run_to_done();
        idle_step();
        step(1'b0, 1'b0, 2, 1'b1, 1'b0, 0, 0);   // PCSrc ignored in DONE

        // branch through lut[2], then same-cycle write vs branch
        lut_write(2, 'h010);
        m_pend = 'h100;
        start_prog();
        run_to_pc(5);
        step(1'b0, 1'b0, 2, 1'b1, 1'b0, 0, 0);   // -> 0x010
        step(1'b0, 1'b0, 'h1F2, 1'b1, 1'b1, 2, 'h020); // old entry 0x010
        step(1'b0, 1'b0, 2, 1'b1, 1'b0, 0, 0);   // -> 0x020

        // branch at prog_end wins, second arrival ends
        lut_write(3, 1);
        m_pend = 7;
        start_prog();
        run_to_pc(7);
        step(1'b0, 1'b0, 3, 1'b1, 1'b0, 0, 0);   // -> 1
        run_to_done();
        idle_step();

        // PC wrap with prog_end = 0
        lut_write(4, 'h3FE);
        m_pend = 0;
        start_prog();
        step(1'b0, 1'b0, 4, 1'b1, 1'b0, 0, 0);   // -> 0x3FE
        run_to_done();
        idle_step();
        step(1'b0, 1'b1, 0, 1'b0, 1'b0, 0, 0);   // start pulse in DONE
        idle_step();
        idle_step();

        // reset mid-RUN clears LUT
        lut_write(1, 'h055);
        m_pend = 'h200;
        start_prog();
        idle_step();
        step(1'b0, 1'b0, 1, 1'b1, 1'b0, 0, 0);   // -> 0x055
        step(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 0);
        idle_step();
        start_prog();
        step(1'b0, 1'b0, 1, 1'b1, 1'b0, 0, 0);   // lut[1] now 0

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bit r, s, src, we;
            int wd;
            if ($urandom_range(0, 63) == 0) m_pend = $urandom_range(0, 15);
            r   = ($urandom_range(0, 299) == 0);
            s   = ($urandom_range(0, 39) == 0);
            src = ($urandom_range(0, 5) == 0);
            we  = ($urandom_range(0, 7) == 0);
            wd  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, PC_MOD - 1)
                                              : $urandom_range(0, 20);
            step(r, s, $urandom_range(0, 511), src, we, $urandom_range(0, 7), wd);
        end

        idle_step();
        @(posedge clk);
        #2;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
